// File: rtl/output_comp_pkg.sv
// Shared types and descriptor layout for the egress packet-buffer reader.
package output_comp_pkg;

  localparam int unsigned PKTBUF_AWIDTH = 16;
  localparam int unsigned LEN_WIDTH     = 16;
  localparam int unsigned DESC_WIDTH    = PKTBUF_AWIDTH + LEN_WIDTH;
  localparam int unsigned DESC_LEN_LSB  = 0;
  localparam int unsigned DESC_BASE_LSB = LEN_WIDTH;
  // Enough bits to hold ceil(65535/64) = 1024.
  localparam int unsigned NFLIT_WIDTH   = LEN_WIDTH - 5;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  typedef struct packed {
    logic       valid;
    logic       sop;
    logic       eop;
    logic [5:0] empty;
  } tag_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFree
  } state_e;

  function automatic logic [NFLIT_WIDTH-1:0] num_flits(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] sum;
    sum = {1'b0, len} + (LEN_WIDTH + 1)'(63);
    return sum[LEN_WIDTH:6];
  endfunction

  function automatic logic [5:0] eop_empty(input logic [LEN_WIDTH-1:0] len);
    return 6'd0 - len[5:0];
  endfunction

endpackage

// File: rtl/output_comp_flit_fifo.sv
// Synchronous flit FIFO with registered storage, occupancy count and same-cycle push/pop.
module out_flit_fifo
  import output_comp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  flit_t            push_flit,
  input  logic             pop,
  output flit_t            head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

  // Upstream credit accounting must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == CNT_W'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));

endmodule

// File: rtl/output_comp.sv
// Egress reader: fetches a packet's flits from the packet buffer, streams them to TX,
// then hands the buffer slot back to the emptylist.
module output_comp
  import output_comp_pkg::*;
#(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     desc_valid,
  input  logic [DESC_WIDTH-1:0]    desc_data,
  output logic                     desc_ready,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
  output logic                     pkt_buffer_read,
  input  logic [511:0]             pkt_buffer_readdata,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [511:0]             out_data,
  output logic [5:0]               out_empty,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     emptylist_valid,
  output logic [PKTBUF_AWIDTH-1:0] emptylist_data,
  input  logic                     emptylist_ready,
  output logic [31:0]              stats_out_pkt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e                   state_q, state_d;
  logic [PKTBUF_AWIDTH-1:0] base_q;
  logic [NFLIT_WIDTH-1:0]   nflits_q, idx_q;
  logic [5:0]               empty_q;
  logic [CNT_W-1:0]         inflight_q, fifo_count;
  logic [31:0]              stats_q;
  tag_t                     tag_q [RD_LAT];

  flit_t fifo_head, push_flit;
  logic  fifo_valid, push, pop, desc_fire, rd_ok, last_rd;

  logic [LEN_WIDTH-1:0]     desc_len;
  logic [PKTBUF_AWIDTH-1:0] desc_base;

  assign desc_len  = desc_data[DESC_LEN_LSB +: LEN_WIDTH];
  assign desc_base = desc_data[DESC_BASE_LSB +: PKTBUF_AWIDTH];
  assign desc_fire = desc_valid & desc_ready;

  // Reads in flight already own a FIFO slot, so count them against the depth.
  assign rd_ok   = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign last_rd = (idx_q == nflits_q - NFLIT_WIDTH'(1));

  assign pkt_buffer_address = base_q + PKTBUF_AWIDTH'(idx_q);
  assign emptylist_data     = base_q;

  always_comb begin
    state_d         = state_q;
    desc_ready      = 1'b0;
    pkt_buffer_read = 1'b0;
    emptylist_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        desc_ready = ~rst;
        if (desc_valid && !rst) state_d = (desc_len == '0) ? StFree : StRead;
      end
      StRead: begin
        if (rd_ok && !rst) begin
          pkt_buffer_read = 1'b1;
          if (last_rd) state_d = StFree;
        end
      end
      StFree: begin
        emptylist_valid = (inflight_q == '0) && !rst;
        if (emptylist_valid && emptylist_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      nflits_q   <= '0;
      idx_q      <= '0;
      empty_q    <= '0;
      inflight_q <= '0;
      stats_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (desc_fire) begin
        base_q   <= desc_base;
        nflits_q <= num_flits(desc_len);
        empty_q  <= eop_empty(desc_len);
        idx_q    <= '0;
      end else if (pkt_buffer_read) begin
        idx_q <= idx_q + NFLIT_WIDTH'(1);
      end
      if (pkt_buffer_read && !push) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (push && !pkt_buffer_read) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end
      tag_q[0] <= '{valid: pkt_buffer_read,
                    sop:   (idx_q == '0),
                    eop:   last_rd,
                    empty: last_rd ? empty_q : 6'd0};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (pop && fifo_head.eop) stats_q <= stats_q + 32'd1;
    end
  end

  assign push      = tag_q[RD_LAT-1].valid;
  assign push_flit = '{data:  pkt_buffer_readdata,
                       sop:   tag_q[RD_LAT-1].sop,
                       eop:   tag_q[RD_LAT-1].eop,
                       empty: tag_q[RD_LAT-1].empty};
  assign pop       = fifo_valid & out_ready;

  out_flit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_flit  (push_flit),
    .pop        (pop),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign out_valid     = fifo_valid;
  assign out_data      = fifo_head.data;
  assign out_sop       = fifo_head.sop;
  assign out_eop       = fifo_head.eop;
  assign out_empty     = fifo_head.empty;
  assign stats_out_pkt = stats_q;

endmodule
